// File: rtl/ir_cmd_uart_tx.sv
// ir_cmd_uart_tx
//
// Turns every accepted command from ir_controller into the 11-byte ASCII frame
// {"cmd":N}\r\n and shifts it out LSB-first as UART 8N1 on tx.
//
// A command is accepted whenever state_control differs from the last snapshot, or
// toggle flips (a resend request with the same value). Accepted commands land in a
// depth-1 mailbox (cmd_q / pending_q): the newest value always wins, and the bytes
// of a frame already on the wire are never altered.
//
// Ports
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset; aborts any frame in flight
//   state_control  in   3  command value, same clock domain
//   toggle         in   1  level; each flip requests a resend
//   tx             out  1  UART serial output, idles high, driven from a flop
//   busy           out  1  high from the start bit to the last stop bit of a frame
//   done           out  1  one-cycle pulse after the final stop bit of a frame
//
// Parameters
//   CLKS_PER_BIT   clock cycles per UART bit (>= 2)

module ir_cmd_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] state_control,
    input  logic       toggle,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CntW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LastByte = 4'd10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_e;

    state_e          state_q;
    logic [2:0]      snap_q;
    logic            tog_q;
    logic [2:0]      cmd_q;
    logic [2:0]      msg_q;
    logic            pending_q;
    logic [3:0]      byte_idx_q;
    logic [2:0]      bit_idx_q;
    logic [CntW-1:0] cnt_q;

    logic            req_event;
    logic            bit_end;
    logic [2:0]      bit_nxt;
    logic [7:0]      cur_byte;

    // A value change and a toggle flip on the same cycle collapse into one event.
    assign req_event = (state_control != snap_q) || (toggle != tog_q);
    assign bit_end   = (cnt_q == CntMax);
    assign bit_nxt   = bit_idx_q + 3'd1;

    // Frame ROM: {"cmd":N}\r\n, only the digit depends on the latched message.
    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_q)
            4'd0:    cur_byte = 8'h7B;
            4'd1:    cur_byte = 8'h22;
            4'd2:    cur_byte = 8'h63;
            4'd3:    cur_byte = 8'h6D;
            4'd4:    cur_byte = 8'h64;
            4'd5:    cur_byte = 8'h22;
            4'd6:    cur_byte = 8'h3A;
            4'd7:    cur_byte = 8'h30 + {5'd0, msg_q};
            4'd8:    cur_byte = 8'h7D;
            4'd9:    cur_byte = 8'h0D;
            4'd10:   cur_byte = 8'h0A;
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            snap_q     <= 3'd0;
            tog_q      <= 1'b0;
            cmd_q      <= 3'd0;
            msg_q      <= 3'd0;
            pending_q  <= 1'b0;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            cnt_q      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Request detect runs in every state; later writes in this block to
            // pending_q are guarded so a coinciding event is never lost.
            if (req_event) begin
                snap_q    <= state_control;
                tog_q     <= toggle;
                cmd_q     <= state_control;
                pending_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (pending_q) begin
                        msg_q      <= cmd_q;
                        if (!req_event) begin
                            pending_q <= 1'b0;
                        end
                        byte_idx_q <= 4'd0;
                        bit_idx_q  <= 3'd0;
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                        tx         <= 1'b0;
                        state_q    <= StStart;
                    end
                end

                StStart: begin
                    if (bit_end) begin
                        cnt_q     <= '0;
                        bit_idx_q <= 3'd0;
                        tx        <= cur_byte[0];
                        state_q   <= StData;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx      <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_nxt;
                            tx        <= cur_byte[bit_nxt];
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (byte_idx_q < LastByte) begin
                            // Next byte starts straight away, no inter-byte idle.
                            byte_idx_q <= byte_idx_q + 4'd1;
                            tx         <= 1'b0;
                            state_q    <= StStart;
                        end else begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            tx      <= 1'b1;
                            state_q <= StDone;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_cmd_uart_tx.sv
module tb_ir_cmd_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] state_control = 3'd0;
    logic       toggle = 1'b0;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    logic [7:0] rx_q[$];   // bytes decoded from tx since the last done
    int         exp_q[$];  // expected digit of each frame, in order

    ir_cmd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .state_control(state_control),
        .toggle       (toggle),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int frame_byte(input int i, input int d);
        case (i)
            0:       return 'h7B;
            1:       return 'h22;
            2:       return 'h63;
            3:       return 'h6D;
            4:       return 'h64;
            5:       return 'h22;
            6:       return 'h3A;
            7:       return 'h30 + d;
            8:       return 'h7D;
            9:       return 'h0D;
            10:      return 'h0A;
            default: return -1;
        endcase
    endfunction

    // UART receiver: samples mid-bit on falling clock edges; a reset aborts the byte.
    initial begin : rx_mon
        logic [7:0] b;
        bit         ok;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_q.delete();
            end else if (tx == 1'b0) begin
                ok = 1'b1;
                b  = 8'h00;
                repeat (CPB / 2) begin
                    @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                end
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) begin
                        @(negedge clk);
                        if (!rst_n) ok = 1'b0;
                    end
                    b[k] = tx;
                end
                repeat (CPB) begin
                    @(negedge clk);
                    if (!rst_n) ok = 1'b0;
                end
                if (ok) begin
                    check("stop bit", int'(tx), 1);
                    rx_q.push_back(b);
                end else begin
                    rx_q.delete();
                end
            end
        end
    end

    // Scoreboard: each done pulse closes a frame and is checked against the queue.
    initial begin : sb_mon
        int d;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected frame", 1, 0);
                end else begin
                    d = exp_q.pop_front();
                    check("frame length", rx_q.size(), 11);
                    for (int i = 0; i < 11; i++) begin
                        check($sformatf("frame digit %0d byte %0d", d, i),
                              (i < rx_q.size()) ? int'(rx_q[i]) : -1, frame_byte(i, d));
                    end
                end
                rx_q.delete();
            end
        end
    end

    task automatic wait_done(input int target, input int budget);
        int c;
        c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("done count reaches %0d", target), done_cnt, target);
    endtask

    task automatic wait_tx_low(input string name, input int budget);
        int c;
        c = 0;
        while (tx !== 1'b0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, int'(tx), 0);
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int bad;
        int d0;
        bad = 0;
        d0  = done_cnt;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check({name, " quiet cycles"}, bad, 0);
        check({name, " no done"}, done_cnt, d0);
    endtask

    initial begin : stim
        int lat;
        int bcnt;
        int gap;
        int c;

        // 1. reset state and long idle
        repeat (3) @(negedge clk);
        check("reset tx", int'(tx), 1);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        rst_n = 1'b1;
        quiet_window("idle", 1000);

        // 2. 0 -> 3: latency, busy length, one done
        @(negedge clk);
        state_control = 3'd3;
        exp_q.push_back(3);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
            if (tx === 1'b0) break;
        end
        check("start latency", lat, 2);
        bcnt = 0;
        c = 0;
        while (done !== 1'b1 && c < 1000) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            c++;
        end
        check("busy length", bcnt, 440);
        repeat (20) @(negedge clk);
        check("single done", done_cnt, 1);

        // 3. toggle flip with unchanged value
        @(negedge clk);
        toggle = 1'b1;
        exp_q.push_back(3);
        wait_done(2, 600);

        // 4. newest command wins while a frame is in flight
        @(negedge clk);
        state_control = 3'd1;
        exp_q.push_back(1);
        wait_tx_low("frame 4 start", 10);
        repeat (50) @(negedge clk);
        state_control = 3'd5;
        repeat (50) @(negedge clk);
        state_control = 3'd2;
        exp_q.push_back(2);
        c = 0;
        while (done !== 1'b1 && c < 600) begin
            @(negedge clk);
            c++;
        end
        gap = 0;
        while (tx !== 1'b0 && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        check("back-to-back gap", gap, 2);
        wait_done(4, 600);

        // 5. reset during byte 4 aborts the frame
        @(negedge clk);
        state_control = 3'd0;
        toggle = 1'b0;
        exp_q.push_back(0);
        wait_tx_low("frame 5 start", 10);
        repeat (4 * 10 * CPB + 2 * CPB) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort tx", int'(tx), 1);
        check("abort busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        quiet_window("post reset", 1000);

        // 6. event on the same edge IDLE accepts the pending request
        @(negedge clk);
        state_control = 3'd4;
        exp_q.push_back(4);
        @(negedge clk);
        state_control = 3'd6;
        exp_q.push_back(6);
        wait_done(6, 1200);

        repeat (20) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
